// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, write-back bypass and optional load-use detection.
// Define LOAD_USE_STALL_EN to build the load-use hazard detector and drive o_stall.
module id_ex_stage (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall_ext,
   input  logic        i_flush,
   input  logic        i_valid,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic [31:0] i_imm,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_shamt,
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_funct,
   input  logic        i_reg_write,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic        i_mem_to_reg,
   input  logic        i_branch,
   input  logic        i_alu_src,
   input  logic        i_reg_dst,
   input  logic        i_wb_reg_write,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   output logic        o_valid,
   output logic [31:0] o_pc_plus4,
   output logic [31:0] o_rs_data,
   output logic [31:0] o_rt_data,
   output logic [31:0] o_imm,
   output logic [4:0]  o_rs,
   output logic [4:0]  o_rt,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_shamt,
   output logic [5:0]  o_opcode,
   output logic [5:0]  o_funct,
   output logic        o_reg_write,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_mem_to_reg,
   output logic        o_branch,
   output logic        o_alu_src,
   output logic        o_reg_dst,
   output logic        o_stall
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc_plus4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
   } id_ex_t;

   id_ex_t ex_q;
   id_ex_t ex_d;
   id_ex_t cap;
   logic   hazard;
   logic   bypass_rs;
   logic   bypass_rt;

`ifdef LOAD_USE_STALL_EN
   logic uses_rt;

   // R-type, sw and beq read rt as a source; everything else writes it or ignores it.
   assign uses_rt = (i_opcode == 6'b000000) || (i_opcode == 6'b101011) ||
                    (i_opcode == 6'b000100);

   assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & i_valid &
                   ((ex_q.rt == i_rs) | ((ex_q.rt == i_rt) & uses_rt));
`else
   assign hazard = 1'b0;
`endif

   // Flush and external hold both override the local stall request.
   assign o_stall = hazard & ~i_flush & ~i_stall_ext;

   // Register file write and read in the same cycle: take the value being written.
   assign bypass_rs = i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs);
   assign bypass_rt = i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_rt);

   always_comb begin
      cap            = '0;
      cap.valid      = i_valid;
      cap.pc_plus4   = i_pc_plus4;
      cap.rs_data    = bypass_rs ? i_wb_data : i_rs_data;
      cap.rt_data    = bypass_rt ? i_wb_data : i_rt_data;
      cap.imm        = i_imm;
      cap.rs         = i_rs;
      cap.rt         = i_rt;
      cap.rd         = i_rd;
      cap.shamt      = i_shamt;
      cap.opcode     = i_opcode;
      cap.funct      = i_funct;
      cap.reg_write  = i_reg_write;
      cap.mem_read   = i_mem_read;
      cap.mem_write  = i_mem_write;
      cap.mem_to_reg = i_mem_to_reg;
      cap.branch     = i_branch;
      cap.alu_src    = i_alu_src;
      cap.reg_dst    = i_reg_dst;
   end

   always_comb begin
      ex_d = ex_q;
      if (i_stall_ext) begin
         ex_d = ex_q;
      end else if (i_flush || o_stall) begin
         ex_d = '0;
      end else begin
         ex_d = cap;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign o_valid      = ex_q.valid;
   assign o_pc_plus4   = ex_q.pc_plus4;
   assign o_rs_data    = ex_q.rs_data;
   assign o_rt_data    = ex_q.rt_data;
   assign o_imm        = ex_q.imm;
   assign o_rs         = ex_q.rs;
   assign o_rt         = ex_q.rt;
   assign o_rd         = ex_q.rd;
   assign o_shamt      = ex_q.shamt;
   assign o_opcode     = ex_q.opcode;
   assign o_funct      = ex_q.funct;
   assign o_reg_write  = ex_q.reg_write;
   assign o_mem_read   = ex_q.mem_read;
   assign o_mem_write  = ex_q.mem_write;
   assign o_mem_to_reg = ex_q.mem_to_reg;
   assign o_branch     = ex_q.branch;
   assign o_alu_src    = ex_q.alu_src;
   assign o_reg_dst    = ex_q.reg_dst;

endmodule
